// File: rtl/jpeg_out_stream_if.sv
// Core data-bus window plus byte-stream valid/ready bundle for jpeg_out_stream.
// master = core/SoC/sink side, slave = the output stage itself.
interface jpeg_out_stream_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] address;
    logic [WIDTH-1:0] wdata;
    logic             enw;
    logic [WIDTH-1:0] rdata;
    logic             hit;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output address, wdata, enw, out_ready,
        input  rdata, hit, out_data, out_valid
    );

    modport slave (
        input  address, wdata, enw, out_ready,
        output rdata, hit, out_data, out_valid
    );
endinterface

// File: rtl/jpeg_out_stream.sv
// Memory-mapped byte FIFO that streams core stores to a valid/ready sink,
// optionally inserting a 0x00 after every 0xFF (JPEG byte stuffing).
module jpeg_out_stream #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 16,
    parameter logic [WIDTH-1:0] BASEADDR = 32'h0000_2000
) (
    input logic         clock,
    input logic         reset,
    jpeg_out_stream_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {ST_DATA = 1'b0, ST_STUFF = 1'b1} state_t;

    logic [7:0]       data_mem [DEPTH];
    logic             tag_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             overflow_reg;
    logic             stuff_en_reg;
    state_t           state_reg;
    state_t           state_next;

    logic             hit;
    logic [1:0]       offset;
    logic             empty;
    logic             full;
    logic             busy;
    logic             push_req;
    logic             push;
    logic             drop;
    logic             ctrl_wr;
    logic             pop;
    logic [7:0]       head_byte;
    logic             head_tag;
    logic             out_valid;
    logic [7:0]       out_data;
    logic [15:0]      status_word;
    logic [WIDTH-1:0] rdata_word;
    logic             unused_bits;

    assign hit      = (bus.address[WIDTH-1:4] == BASEADDR[WIDTH-1:4]);
    assign offset   = bus.address[3:2];
    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign busy     = !empty || (state_reg == ST_STUFF);
    assign push_req = bus.enw && hit && (offset == 2'd0);
    // Fullness is judged at cycle start, so a same-cycle pop never rescues a push.
    assign push     = push_req && !full;
    assign drop     = push_req && full;
    assign ctrl_wr  = bus.enw && hit && (offset == 2'd2);

    assign head_byte   = data_mem[rd_ptr_reg];
    assign head_tag    = tag_mem[rd_ptr_reg];
    assign unused_bits = ^bus.address[1:0];

    always_ff @(posedge clock) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= bus.wdata[7:0];
            tag_mem[wr_ptr_reg]  <= stuff_en_reg;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            stuff_en_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
            if (ctrl_wr) stuff_en_reg <= bus.wdata[0];
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (ctrl_wr && bus.wdata[1]) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_DATA;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_DATA:  if (pop && head_byte == 8'hFF && head_tag) state_next = ST_STUFF;
            ST_STUFF: if (bus.out_ready) state_next = ST_DATA;
            default:  state_next = ST_DATA;
        endcase
    end

    // The FIFO head stays put while the stuffing zero is on the bus.
    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        pop       = 1'b0;
        case (state_reg)
            ST_DATA: begin
                out_valid = !empty;
                out_data  = empty ? 8'h00 : head_byte;
                pop       = !empty && bus.out_ready;
            end
            ST_STUFF: begin
                out_valid = 1'b1;
                out_data  = 8'h00;
            end
            default: ;
        endcase
    end

    assign status_word = {8'(count_reg), 4'b0000, busy, overflow_reg, full, empty};

    always_comb begin
        rdata_word = '0;
        if (hit) begin
            case (offset)
                2'd1:    rdata_word = WIDTH'(status_word);
                2'd2:    rdata_word = WIDTH'(stuff_en_reg);
                default: rdata_word = '0;
            endcase
        end
    end

    assign bus.rdata     = rdata_word;
    assign bus.hit       = hit;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
endmodule

// File: tb/tb_jpeg_out_stream.sv
// Bench for jpeg_out_stream: register table plus directed multi-cycle sequences,
// with a byte scoreboard checked by a stream monitor.
module tb_jpeg_out_stream;
    localparam int          WIDTH  = 32;
    localparam int          DEPTH  = 16;
    localparam logic [31:0] BASE   = 32'h0000_2000;
    localparam logic [31:0] A_DATA = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'd4;
    localparam logic [31:0] A_CTRL = BASE + 32'd8;
    localparam logic [31:0] A_RSV  = BASE + 32'd12;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    jpeg_out_stream_if #(.WIDTH(WIDTH)) bus ();

    jpeg_out_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BASEADDR(BASE)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] sb[$];
    bit         mon_en   = 1'b0;
    bit         stores_done;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_hit;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.address = a;
        bus.wdata   = d;
        bus.enw     = 1'b1;
        @(posedge clock);
        #1;
        bus.enw = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
        bus.address = a;
        bus.enw     = 1'b0;
        #1;
        d = bus.rdata;
        h = bus.hit;
    endtask

    task automatic store(input logic [7:0] b, input bit stuff, input bit accept);
        if (accept) begin
            sb.push_back(b);
            if (stuff && b == 8'hFF) sb.push_back(8'h00);
        end
        wr(A_DATA, {24'h5A5A5A, b});
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 3000) begin
            tick(1);
            n++;
        end
        check(name, 32'(sb.size()), 32'd0);
    endtask

    // Stream monitor: sampled mid-cycle, i.e. the values the next rising edge sees.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    always @(negedge clock) begin
        logic [7:0] exp_b;
        if (!mon_en || reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data", 32'(bus.out_data), 32'(prev_data));
            end
            if (!bus.out_valid) check("idle_data", 32'(bus.out_data), 32'd0);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte: got 0x%02h expected nothing", bus.out_data);
                end else begin
                    exp_b = sb.pop_front();
                    check("stream_byte", 32'(bus.out_data), 32'(exp_b));
                    $display("out byte 0x%02h (expected 0x%02h)", bus.out_data, exp_b);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[17];
        logic [31:0] d;
        logic        h;
        int          k;

        vecs[0]  = '{1'b0, A_STAT,           32'h0,          1'b1, 32'h0000_0001};
        vecs[1]  = '{1'b0, A_CTRL,           32'h0,          1'b1, 32'h0};
        vecs[2]  = '{1'b1, A_CTRL,           32'h1,          1'b1, 32'h0};
        vecs[3]  = '{1'b0, A_CTRL,           32'h0,          1'b1, 32'h1};
        vecs[4]  = '{1'b1, A_CTRL,           32'hFFFF_FFFE,  1'b1, 32'h0};
        vecs[5]  = '{1'b0, A_CTRL,           32'h0,          1'b1, 32'h0};
        vecs[6]  = '{1'b1, A_DATA,           32'h1234_5655,  1'b1, 32'h0};
        vecs[7]  = '{1'b0, A_STAT,           32'h0,          1'b1, 32'h0000_0108};
        vecs[8]  = '{1'b0, A_DATA,           32'h0,          1'b1, 32'h0};
        vecs[9]  = '{1'b0, A_RSV,            32'h0,          1'b1, 32'h0};
        vecs[10] = '{1'b1, A_RSV,            32'hFFFF_FFFF,  1'b1, 32'h0};
        vecs[11] = '{1'b1, A_STAT,           32'hFFFF_FFFF,  1'b1, 32'h0};
        vecs[12] = '{1'b0, A_STAT,           32'h0,          1'b1, 32'h0000_0108};
        vecs[13] = '{1'b0, 32'h0000_3004,    32'h0,          1'b0, 32'h0};
        vecs[14] = '{1'b1, 32'h0000_3000,    32'h77,         1'b0, 32'h0};
        vecs[15] = '{1'b0, 32'h0000_2006,    32'h0,          1'b1, 32'h0000_0108};
        vecs[16] = '{1'b0, 32'h0000_1FF8,    32'h0,          1'b0, 32'h0};

        bus.address   = '0;
        bus.wdata     = '0;
        bus.enw       = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        reset = 1'b1;
        tick(3);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        rd(A_STAT, d, h);
        check("rst_status", d, 32'h1);
        reset  = 1'b0;
        tick(1);
        mon_en = 1'b1;

        // Register window table (sink stalled so FIFO contents are known)
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].we) begin
                if (vecs[i].addr[31:4] == BASE[31:4] && vecs[i].addr[3:2] == 2'd0)
                    sb.push_back(vecs[i].data[7:0]);
                wr(vecs[i].addr, vecs[i].data);
                $display("vec %0d write addr=0x%08h data=0x%08h", i, vecs[i].addr, vecs[i].data);
            end else begin
                rd(vecs[i].addr, d, h);
                $display("vec %0d read addr=0x%08h rdata=0x%08h hit=%0d", i, vecs[i].addr, d, h);
                check($sformatf("vec%0d_hit", i), 32'(h), 32'(vecs[i].exp_hit));
                check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
            end
        end
        bus.out_ready = 1'b1;
        drain("table_drain");

        // 1: in-order stream, first byte visible one cycle after its store
        check("t1_idle_valid", 32'(bus.out_valid), 32'd0);
        store(8'h41, 1'b0, 1'b1);
        check("t1_first_valid", 32'(bus.out_valid), 32'd1);
        check("t1_first_data", 32'(bus.out_data), 32'h41);
        store(8'h42, 1'b0, 1'b1);
        store(8'h43, 1'b0, 1'b1);
        drain("t1_drain");
        rd(A_STAT, d, h);
        check("t1_status", d, 32'h1);

        // 2: stuffing on, busy held through the inserted zero
        bus.out_ready = 1'b0;
        wr(A_CTRL, 32'h1);
        store(8'hFF, 1'b1, 1'b1);
        rd(A_STAT, d, h);
        check("t2_status_ff", d, 32'h0000_0108);
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
        rd(A_STAT, d, h);
        check("t2_status_stuff", d, 32'h9);
        check("t2_stuff_valid", 32'(bus.out_valid), 32'd1);
        check("t2_stuff_data", 32'(bus.out_data), 32'd0);
        bus.out_ready = 1'b1;
        tick(1);
        rd(A_STAT, d, h);
        check("t2_status_done", d, 32'h1);
        store(8'h12, 1'b1, 1'b1);
        drain("t2_drain_a");
        wr(A_CTRL, 32'h0);
        store(8'hFF, 1'b0, 1'b1);
        drain("t2_drain_b");

        // 3: overflow on a stalled sink, then clear
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) store(8'(8'h10 + i), 1'b0, i < DEPTH);
        rd(A_STAT, d, h);
        check("t3_status_full", d, 32'h0000_100E);
        bus.out_ready = 1'b1;
        drain("t3_drain");
        rd(A_STAT, d, h);
        check("t3_status_ovf", d, 32'h5);
        wr(A_CTRL, 32'h2);
        rd(A_STAT, d, h);
        check("t3_status_clr", d, 32'h1);
        rd(A_CTRL, d, h);
        check("t3_ctrl", d, 32'h0);

        // 4: full FIFO, push and pop in the same cycle
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) store(8'(8'h60 + i), 1'b0, 1'b1);
        bus.out_ready = 1'b1;
        store(8'hEE, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        rd(A_STAT, d, h);
        check("t4_status", d, 32'h0000_0F0C);
        wr(A_CTRL, 32'h2);
        rd(A_STAT, d, h);
        check("t4_status_clr", d, 32'h0000_0F08);
        bus.out_ready = 1'b1;
        drain("t4_drain");

        // 5: random sink stalls over 200 stuffed bytes
        wr(A_CTRL, 32'h1);
        stores_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    logic [7:0] b;
                    rd(A_STAT, d, h);
                    k = 0;
                    while (d[1] && k < 1000) begin
                        tick(1);
                        rd(A_STAT, d, h);
                        k++;
                    end
                    check("t5_not_full", 32'(d[1]), 32'd0);
                    b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
                    store(b, 1'b1, 1'b1);
                end
                stores_done = 1'b1;
            end
            begin
                int n;
                n = 0;
                while ((!stores_done || sb.size() != 0) && n < 20000) begin
                    bus.out_ready = ($urandom_range(0, 1) == 1);
                    tick(1);
                    n++;
                end
            end
        join
        bus.out_ready = 1'b1;
        drain("t5_drain");

        // 6: reset while inserting a stuffing zero with three bytes queued
        bus.out_ready = 1'b0;
        store(8'hFF, 1'b1, 1'b1);
        store(8'h01, 1'b1, 1'b1);
        store(8'h02, 1'b1, 1'b1);
        store(8'h03, 1'b1, 1'b1);
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
        check("t6_stuff_valid", 32'(bus.out_valid), 32'd1);
        check("t6_stuff_data", 32'(bus.out_data), 32'd0);
        rd(A_STAT, d, h);
        check("t6_status_pre", d, 32'h0000_0308);
        mon_en = 1'b0;
        reset  = 1'b1;
        tick(1);
        check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        check("t6_rst_data", 32'(bus.out_data), 32'd0);
        rd(A_STAT, d, h);
        check("t6_rst_status", d, 32'h1);
        rd(A_CTRL, d, h);
        check("t6_rst_ctrl", d, 32'h0);
        reset = 1'b0;
        sb.delete();
        tick(1);
        mon_en = 1'b1;
        rd(32'h0000_2010, d, h);
        check("t6_out_hit", 32'(h), 32'd0);
        check("t6_out_rdata", d, 32'h0);
        rd(32'h8000_2004, d, h);
        check("t6_out_hit_hi", 32'(h), 32'd0);
        check("t6_out_rdata_hi", d, 32'h0);
        bus.out_ready = 1'b1;
        store(8'hFF, 1'b0, 1'b1);
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
